// File: rtl/gf22_pad_input_conditioner.sv
// Receive-side pad conditioner: synchronizes and debounces the raw pad receiver
// output and drives the pad receive controls (RXEN/SMT/PUEN/PDEN).
module gf22_pad_input_conditioner #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 16,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             pad_y_i,
  input  logic [CNT_W-1:0] debounce_cycles_i,
  input  logic             smt_en_i,
  input  logic [1:0]       pull_sel_i,
  input  logic [1:0]       edge_sel_i,
  input  logic             event_clr_i,
  output logic             rxen_o,
  output logic             smt_o,
  output logic             puen_o,
  output logic             pden_o,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             event_pending_o
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_STABLE  = 2'd2,
    ST_QUALIFY = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   event_q, event_d;
  logic                   rxen_q, rxen_d;
  logic                   smt_q, smt_d;
  logic                   puen_q, puen_d;
  logic                   pden_q, pden_d;
  logic                   synced_s;
  logic                   event_set_s;
  logic [CNT_W:0]         cnt_inc_s;
  logic [CNT_W:0]         deb_ext_s;

  // One extra bit so cnt+1 can never wrap before the compare.
  assign synced_s  = sync_q[SYNC_STAGES-1];
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], pad_y_i};
  assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign deb_ext_s = {1'b0, debounce_cycles_i};

  // Next-state, debounce counter and level/pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!en_i) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_WARMUP;
          cnt_d   = '0;
        end
        ST_WARMUP: begin
          if (cnt_q >= CNT_W'(SYNC_STAGES - 1)) begin
            level_d = synced_s;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_inc_s[CNT_W-1:0];
          end
        end
        ST_STABLE: begin
          if (synced_s != level_q) begin
            if (debounce_cycles_i <= CNT_W'(1)) begin
              level_d = synced_s;
              rise_d  = synced_s;
              fall_d  = ~synced_s;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_QUALIFY;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_QUALIFY: begin
          if (synced_s == level_q) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_inc_s >= deb_ext_s) begin
            level_d = synced_s;
            rise_d  = synced_s;
            fall_d  = ~synced_s;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_inc_s[CNT_W-1:0];
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pad controls and sticky event flag; a set in the same cycle as a clear wins.
  always_comb begin
    rxen_d      = (state_d != ST_OFF);
    smt_d       = smt_en_i & rxen_d;
    puen_d      = (pull_sel_i == 2'b01);
    pden_d      = (pull_sel_i == 2'b10);
    event_set_s = (rise_d & edge_sel_i[0]) | (fall_d & edge_sel_i[1]);
    if (event_set_s) begin
      event_d = 1'b1;
    end else if (event_clr_i) begin
      event_d = 1'b0;
    end else begin
      event_d = event_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      state_q <= ST_OFF;
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      event_q <= 1'b0;
      rxen_q  <= 1'b0;
      smt_q   <= 1'b0;
      puen_q  <= 1'b0;
      pden_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
      rxen_q  <= rxen_d;
      smt_q   <= smt_d;
      puen_q  <= puen_d;
      pden_q  <= pden_d;
    end
  end

  assign rxen_o          = rxen_q;
  assign smt_o           = smt_q;
  assign puen_o          = puen_q;
  assign pden_o          = pden_q;
  assign level_o         = level_q;
  assign rise_o          = rise_q;
  assign fall_o          = fall_q;
  assign event_pending_o = event_q;

endmodule

// File: tb/tb_gf22_pad_input_conditioner.sv
// Scoreboard bench for gf22_pad_input_conditioner: expected level changes are
// queued when the pad is driven and popped when a rise/fall pulse appears.
module tb_gf22_pad_input_conditioner;
  localparam int S  = 2;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i, en_i, pad_y_i, smt_en_i, event_clr_i;
  logic [CW-1:0] debounce_cycles_i;
  logic [1:0]    pull_sel_i, edge_sel_i;
  logic          rxen_o, smt_o, puen_o, pden_o, level_o, rise_o, fall_o, event_pending_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic lvl;
    logic rise;
    logic fall;
    int   due;
  } exp_t;
  exp_t sb[$];

  gf22_pad_input_conditioner #(.SYNC_STAGES(S), .CNT_W(CW), .RESET_VAL(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .pad_y_i(pad_y_i),
    .debounce_cycles_i(debounce_cycles_i), .smt_en_i(smt_en_i),
    .pull_sel_i(pull_sel_i), .edge_sel_i(edge_sel_i), .event_clr_i(event_clr_i),
    .rxen_o(rxen_o), .smt_o(smt_o), .puen_o(puen_o), .pden_o(pden_o),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .event_pending_o(event_pending_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Drive a held pad change and queue the expected accepted transition.
  task automatic drive_change(input logic v, input int d);
    debounce_cycles_i = CW'(d);
    pad_y_i = v;
    sb.push_back('{v, v, ~v, cyc + S + ((d <= 1) ? 1 : d)});
  endtask

  // Observe the next pulse (bounded) and pop its queued expectation.
  task automatic next_pulse(input int budget, output bit ok, output logic [2:0] obs,
                            output int at, output exp_t e);
    bit seen = 1'b0;
    obs = 3'b000;
    at  = -1;
    e   = '{1'b0, 1'b0, 1'b0, -2};
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (rise_o || fall_o) begin
        seen = 1'b1;
        obs  = {rise_o, fall_o, level_o};
        at   = cyc;
      end
    end
    ok = seen && (sb.size() > 0);
    if (sb.size() > 0) e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b0; pad_y_i = 1'b0; smt_en_i = 1'b1; event_clr_i = 1'b0;
    debounce_cycles_i = 16'd1; pull_sel_i = 2'b01; edge_sel_i = 2'b01;
    tick(2);
    pad_y_i = 1'b1;
    tick(2);
    total++;
    if ({rxen_o, smt_o, puen_o, pden_o, level_o, rise_o, fall_o, event_pending_o} !== 8'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {rxen_o, smt_o, puen_o, pden_o, level_o, rise_o, fall_o, event_pending_o});
    end
    rst_i = 1'b0; pull_sel_i = 2'b00;
    tick(3);
  endtask

  task automatic test_enable();
    logic rise_any = 1'b0;
    en_i = 1'b1;
    tick(1);
    rise_any |= rise_o;
    total++;
    if ({rxen_o, smt_o, level_o} !== 3'b110) begin
      bad++; $display("FAIL enable_rxen: rxen/smt/level=%b required 110", {rxen_o, smt_o, level_o});
    end
    tick(1);
    rise_any |= rise_o;
    total++;
    if (level_o !== 1'b0) begin
      bad++; $display("FAIL warmup_hold: level=%b required 0", level_o);
    end
    tick(1);
    rise_any |= rise_o;
    total++;
    if (level_o !== 1'b1) begin
      bad++; $display("FAIL warmup_level: level=%b required 1", level_o);
    end
    tick(2);
    rise_any |= rise_o;
    total++;
    if ({rise_any, event_pending_o} !== 2'b00) begin
      bad++; $display("FAIL warmup_no_rise: rise_seen/event=%b required 00", {rise_any, event_pending_o});
    end
    pull_sel_i = 2'b01;
    tick(1);
    total++;
    if ({puen_o, pden_o} !== 2'b10) begin
      bad++; $display("FAIL pull_up: puen/pden=%b required 10", {puen_o, pden_o});
    end
    pull_sel_i = 2'b10;
    tick(1);
    total++;
    if ({puen_o, pden_o} !== 2'b01) begin
      bad++; $display("FAIL pull_down: puen/pden=%b required 01", {puen_o, pden_o});
    end
    pull_sel_i = 2'b00;
  endtask

  task automatic test_fast();
    bit ok; logic [2:0] obs; int at; exp_t e;
    for (int k = 0; k < 3; k++) begin
      edge_sel_i = (k == 1) ? 2'b10 : 2'b01;
      drive_change((k == 1) ? 1'b1 : 1'b0, (k == 0) ? 0 : 1);
      next_pulse(20, ok, obs, at, e);
      total++;
      if (!ok || obs !== {e.rise, e.fall, e.lvl} || at != e.due) begin
        bad++;
        $display("FAIL fast_d%0d: rfl=%b at=%0d required rfl=%b%b%b at=%0d",
                 (k == 0) ? 0 : 1, obs, at, e.rise, e.fall, e.lvl, e.due);
      end
      tick(1);
      total++;
      if ({rise_o, fall_o, event_pending_o} !== 3'b000) begin
        bad++; $display("FAIL fast_masked_%0d: rise/fall/event=%b required 000", k,
                        {rise_o, fall_o, event_pending_o});
      end
    end
  endtask

  task automatic test_debounce();
    bit ok; logic [2:0] obs; int at; exp_t e;
    edge_sel_i = 2'b01;
    drive_change(1'b1, 4);
    next_pulse(30, ok, obs, at, e);
    total++;
    if (!ok || obs !== {e.rise, e.fall, e.lvl} || at != e.due) begin
      bad++;
      $display("FAIL debounce_rise: rfl=%b at=%0d required rfl=%b%b%b at=%0d",
               obs, at, e.rise, e.fall, e.lvl, e.due);
    end
    tick(1);
    total++;
    if ({rise_o, level_o, event_pending_o} !== 3'b011) begin
      bad++; $display("FAIL debounce_after: rise/level/event=%b required 011",
                      {rise_o, level_o, event_pending_o});
    end
  endtask

  task automatic test_glitch();
    bit ok; logic [2:0] obs; int at; exp_t e;
    logic pulse_any = 1'b0;
    event_clr_i = 1'b1;
    tick(1);
    event_clr_i = 1'b0;
    drive_change(1'b0, 1);
    next_pulse(20, ok, obs, at, e);
    total++;
    if (!ok || obs !== {e.rise, e.fall, e.lvl} || at != e.due) begin
      bad++;
      $display("FAIL glitch_setup: rfl=%b at=%0d required rfl=%b%b%b at=%0d",
               obs, at, e.rise, e.fall, e.lvl, e.due);
    end
    debounce_cycles_i = 16'd4;
    pad_y_i = 1'b1;
    tick(2);
    pad_y_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      pulse_any |= rise_o | fall_o;
    end
    total++;
    if ({pulse_any, level_o} !== 2'b00) begin
      bad++; $display("FAIL glitch_reject: pulse_seen/level=%b required 00", {pulse_any, level_o});
    end
    drive_change(1'b1, 1);
    next_pulse(20, ok, obs, at, e);
    total++;
    if (!ok || obs !== {e.rise, e.fall, e.lvl} || at != e.due) begin
      bad++;
      $display("FAIL glitch_back_stable: rfl=%b at=%0d required rfl=%b%b%b at=%0d",
               obs, at, e.rise, e.fall, e.lvl, e.due);
    end
  endtask

  task automatic test_event_clr();
    bit ok; logic [2:0] obs; int at; exp_t e;
    edge_sel_i = 2'b01;
    event_clr_i = 1'b1;
    tick(1);
    event_clr_i = 1'b0;
    total++;
    if (event_pending_o !== 1'b0) begin
      bad++; $display("FAIL event_clear: event=%b required 0", event_pending_o);
    end
    drive_change(1'b0, 1);
    next_pulse(20, ok, obs, at, e);
    total++;
    if (!ok || obs !== {e.rise, e.fall, e.lvl} || at != e.due || event_pending_o !== 1'b0) begin
      bad++;
      $display("FAIL event_fall_masked: rfl=%b at=%0d event=%b required rfl=%b%b%b at=%0d event=0",
               obs, at, event_pending_o, e.rise, e.fall, e.lvl, e.due);
    end
    drive_change(1'b1, 1);
    tick(2);
    event_clr_i = 1'b1;
    tick(1);
    e = sb.pop_front();
    total++;
    if ({rise_o, fall_o, level_o, event_pending_o} !== {e.rise, e.fall, e.lvl, 1'b1} || cyc != e.due) begin
      bad++;
      $display("FAIL event_set_wins: rfl/event=%b at=%0d required %b%b%b1 at=%0d",
               {rise_o, fall_o, level_o, event_pending_o}, cyc, e.rise, e.fall, e.lvl, e.due);
    end
    event_clr_i = 1'b0;
    tick(1);
    total++;
    if ({rise_o, event_pending_o} !== 2'b01) begin
      bad++; $display("FAIL event_sticky: rise/event=%b required 01", {rise_o, event_pending_o});
    end
    event_clr_i = 1'b1;
    tick(1);
    event_clr_i = 1'b0;
    total++;
    if (event_pending_o !== 1'b0) begin
      bad++; $display("FAIL event_late_clear: event=%b required 0", event_pending_o);
    end
  endtask

  task automatic test_abort();
    logic pulse_any = 1'b0;
    edge_sel_i = 2'b11;
    debounce_cycles_i = 16'd4;
    pad_y_i = 1'b0;
    tick(4);
    en_i = 1'b0;
    tick(1);
    total++;
    if ({rxen_o, smt_o, rise_o, fall_o, level_o} !== 5'b00001) begin
      bad++; $display("FAIL abort_en: rxen/smt/rise/fall/level=%b required 00001",
                      {rxen_o, smt_o, rise_o, fall_o, level_o});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      pulse_any |= rise_o | fall_o;
    end
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pulse_any |= rise_o | fall_o;
    end
    total++;
    if ({pulse_any, level_o, event_pending_o, rxen_o} !== 4'b0001) begin
      bad++; $display("FAIL abort_reenable: pulse_seen/level/event/rxen=%b required 0001",
                      {pulse_any, level_o, event_pending_o, rxen_o});
    end
    pad_y_i = 1'b1;
    tick(4);
    rst_i = 1'b1;
    pull_sel_i = 2'b11;
    tick(1);
    total++;
    if ({rxen_o, smt_o, puen_o, pden_o, level_o, rise_o, fall_o, event_pending_o} !== 8'b0) begin
      bad++;
      $display("FAIL abort_reset: got %b required 00000000",
               {rxen_o, smt_o, puen_o, pden_o, level_o, rise_o, fall_o, event_pending_o});
    end
    tick(1);
    rst_i = 1'b0;
    pulse_any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      pulse_any |= rise_o | fall_o;
    end
    total++;
    if ({pulse_any, rxen_o, level_o, puen_o, pden_o} !== 5'b01100) begin
      bad++; $display("FAIL pull_none_warmup: pulse_seen/rxen/level/puen/pden=%b required 01100",
                      {pulse_any, rxen_o, level_o, puen_o, pden_o});
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_fast();
    test_debounce();
    test_glitch();
    test_event_clr();
    test_abort();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
